// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller, datapath and bench:
// FSM state encodings, BCD digit width and a state-decoding helper.
package stopwatch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int BCD_BIT_WIDTH = 4;

  typedef logic [1:0] state_t;

  // True in the states where the prescaler runs and the count advances.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/datapath bundle of the stopwatch controller.
// master: the controller (consumes buttons and max flag, drives counter controls).
// slave : the board/datapath side.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       cnt_at_max;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic       state_led;
  logic [1:0] state;

  modport master (
    input  btn_start, btn_lap, cnt_at_max,
    output cnt_en, cnt_clr, disp_hold, state_led, state
  );

  modport slave (
    output btn_start, btn_lap, cnt_at_max,
    input  cnt_en, cnt_clr, disp_hold, state_led, state
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-FF synchronizer, DB_LEN-sample
// debounce (all samples high), rising-edge detect. A button that is already
// held when reset releases has to be let go before it can produce a press.
module btn_conditioner #(
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  logic              sync1;
  logic              sync2;
  logic [DB_LEN-1:0] shift;
  logic              db;
  logic              db_q;
  logic [1:0]        fill;
  logic              armed;

  assign db    = &shift;
  assign press = db & ~db_q & armed;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce history of synchronized samples plus the delayed level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      db_q  <= 1'b0;
    end else begin
      shift <= {shift[DB_LEN-2:0], sync2};
      db_q  <= db;
    end
  end

  // Arm only once a real synchronized low has been seen; fill marks when sync2
  // holds a pin sample rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & ~sync2);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions the start/stop and lap/reset buttons, runs the
// IDLE/RUN/PAUSE/LAP FSM, divides clk down to the count tick and drives the
// counter enable, clear and display-hold controls.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV         = 10,
  parameter int          DB_LEN      = 4,
  parameter bit          STOP_AT_MAX = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.master bus
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic             p_start;
  logic             p_lap;
  state_t           state;
  state_t           state_nx;
  logic             clr_nx;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             max_stop;
  logic             cnt_en;
  logic             cnt_clr;
  logic             disp_hold;
  logic             state_led;

  btn_conditioner #(.DB_LEN(DB_LEN)) u_btn_start (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_start),
    .press (p_start)
  );

  btn_conditioner #(.DB_LEN(DB_LEN)) u_btn_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_lap),
    .press (p_lap)
  );

  // Last prescaler cycle of a count period; at 59 it may become an auto-pause.
  assign tick     = is_counting(state) && (pre == PRE_LAST);
  assign max_stop = STOP_AT_MAX && bus.cnt_at_max && tick;

  // Next-state decode; start/stop has priority over lap in every state.
  always_comb begin
    state_nx = state;
    clr_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p_start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (p_start || max_stop) state_nx = ST_PAUSE;
        else if (p_lap)          state_nx = ST_LAP;
      end
      ST_LAP: begin
        if (p_start || max_stop) state_nx = ST_PAUSE;
        else if (p_lap)          state_nx = ST_RUN;
      end
      ST_PAUSE: begin
        if (p_start) begin
          state_nx = ST_RUN;
        end else if (p_lap) begin
          state_nx = ST_IDLE;
          clr_nx   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Prescaler: runs while counting, keeps the fractional period in PAUSE, zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else begin
      case (state)
        ST_RUN, ST_LAP: pre <= tick ? '0 : pre + 1'b1;
        ST_PAUSE:       pre <= pre;
        default:        pre <= '0;
      endcase
    end
  end

  // State and registered outputs, all decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_hold <= 1'b0;
      state_led <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt_en    <= tick & ~max_stop;
      cnt_clr   <= clr_nx;
      disp_hold <= (state_nx == ST_LAP);
      state_led <= is_counting(state_nx);
    end
  end

  assign bus.cnt_en    = cnt_en;
  assign bus.cnt_clr   = cnt_clr;
  assign bus.disp_hold = disp_hold;
  assign bus.state_led = state_led;
  assign bus.state     = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (auto-pause at max on / off) share
// the button and max-flag stimulus. Expected cnt_en cycles are queued when a
// scenario is driven and consumed as the DUT pulses.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_start = 1'b0;
  logic b_lap = 1'b0;
  logic at_max = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   en_q[$];

  stopwatch_ctrl_if ifa ();
  stopwatch_ctrl_if ifb ();

  assign ifa.btn_start  = b_start;
  assign ifa.btn_lap    = b_lap;
  assign ifa.cnt_at_max = at_max;
  assign ifb.btn_start  = b_start;
  assign ifb.btn_lap    = b_lap;
  assign ifb.cnt_at_max = at_max;

  stopwatch_ctrl #(.DIV(10), .DB_LEN(4), .STOP_AT_MAX(1'b1)) u_dut_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  stopwatch_ctrl #(.DIV(10), .DB_LEN(4), .STOP_AT_MAX(1'b0)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0; b_start = 1'b0; b_lap = 1'b0; at_max = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    en_q.delete();
  endtask

  // Press start from IDLE; returns the cycle at which RUN becomes visible.
  task automatic go_run(output int r);
    @(negedge clk);
    b_start = 1'b1;
    repeat (6) @(negedge clk);
    b_start = 1'b0;
    n_chk++;
    if (ifa.state !== ST_IDLE) begin
      n_fail++; $display("FAIL go_run_early: state=%0d want %0d", ifa.state, ST_IDLE);
    end
    @(negedge clk);
    n_chk++;
    if (ifa.state !== ST_RUN) begin
      n_fail++; $display("FAIL go_run: state=%0d want %0d", ifa.state, ST_RUN);
    end
    r = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b_start = 1'b1; b_lap = 1'b1; at_max = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (ifa.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", ifa.state); end
    n_chk++; if (ifa.cnt_en !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_en: got %b want 0", ifa.cnt_en); end
    n_chk++; if (ifa.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_clr: got %b want 0", ifa.cnt_clr); end
    n_chk++; if (ifa.disp_hold !== 1'b0) begin n_fail++; $display("FAIL rst_disp_hold: got %b want 0", ifa.disp_hold); end
    n_chk++; if (ifa.state_led !== 1'b0) begin n_fail++; $display("FAIL rst_state_led: got %b want 0", ifa.state_led); end
    n_chk++; if (ifb.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state_wrap: got %0d want 0", ifb.state); end
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      n_chk++;
      if (ifa.state !== ST_IDLE || ifa.cnt_en !== 1'b0) begin
        n_fail++; $display("FAIL rst_held_btn: state=%0d cnt_en=%b want IDLE/0", ifa.state, ifa.cnt_en);
      end
    end
    b_start = 1'b0; b_lap = 1'b0;
    repeat (6) @(negedge clk);
    b_start = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++; if (ifa.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_repress_6: got %0d want 0", ifa.state); end
    @(negedge clk);
    n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL rst_repress_7: got %0d want 1", ifa.state); end
    b_start = 1'b0;
  endtask

  task automatic test_start();
    int n0;
    int rel;
    restart();
    @(negedge clk);
    n0 = cyc;
    b_start = 1'b1;
    en_q.push_back(n0 + 17); en_q.push_back(n0 + 27); en_q.push_back(n0 + 37);
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      rel = cyc - n0;
      if (rel == 10) b_start = 1'b0;
      while (en_q.size() != 0 && en_q[0] < cyc) begin
        n_chk++; n_fail++; $display("FAIL start_en_missed: none at %0d", en_q.pop_front());
      end
      if (ifa.cnt_en) begin
        n_chk++;
        if (en_q.size() == 0 || en_q[0] != cyc) begin
          n_fail++; $display("FAIL start_en_extra: pulse at rel %0d", rel);
        end else void'(en_q.pop_front());
      end
      if (rel == 6) begin
        n_chk++; if (ifa.state !== ST_IDLE) begin n_fail++; $display("FAIL start_edge6: got %0d want 0", ifa.state); end
      end
      if (rel == 7) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL start_edge7: got %0d want 1", ifa.state); end
        n_chk++; if (ifa.state_led !== 1'b1) begin n_fail++; $display("FAIL start_led: got %b want 1", ifa.state_led); end
      end
      if (rel == 41) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL start_single: got %0d want 1", ifa.state); end
      end
    end
    n_chk++; if (en_q.size() != 0) begin n_fail++; $display("FAIL start_en_left: %0d pending want 0", en_q.size()); end
  endtask

  task automatic test_lap();
    int r;
    int rel;
    restart();
    go_run(r);
    for (int m = 1; m <= 4; m++) en_q.push_back(r + 10 * m);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      rel = cyc - r;
      if (rel == 3 || rel == 15) b_lap = 1'b1;
      if (rel == 9 || rel == 21) b_lap = 1'b0;
      while (en_q.size() != 0 && en_q[0] < cyc) begin
        n_chk++; n_fail++; $display("FAIL lap_en_missed: none at %0d", en_q.pop_front());
      end
      if (ifa.cnt_en) begin
        n_chk++;
        if (en_q.size() == 0 || en_q[0] != cyc) begin
          n_fail++; $display("FAIL lap_en_extra: pulse at rel %0d", rel);
        end else void'(en_q.pop_front());
      end
      if (rel == 9) begin
        n_chk++; if (ifa.disp_hold !== 1'b0) begin n_fail++; $display("FAIL lap_hold_pre: got %b want 0", ifa.disp_hold); end
      end
      if (rel == 10) begin
        n_chk++; if (ifa.state !== ST_LAP) begin n_fail++; $display("FAIL lap_enter: got %0d want 3", ifa.state); end
        n_chk++; if (ifa.disp_hold !== 1'b1) begin n_fail++; $display("FAIL lap_hold: got %b want 1", ifa.disp_hold); end
        n_chk++; if (ifa.state_led !== 1'b1) begin n_fail++; $display("FAIL lap_led: got %b want 1", ifa.state_led); end
      end
      if (rel == 22) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL lap_resume: got %0d want 1", ifa.state); end
        n_chk++; if (ifa.disp_hold !== 1'b0) begin n_fail++; $display("FAIL lap_unhold: got %b want 0", ifa.disp_hold); end
      end
    end
    n_chk++; if (en_q.size() != 0) begin n_fail++; $display("FAIL lap_en_left: %0d pending want 0", en_q.size()); end
  endtask

  task automatic test_pause_clear();
    int r;
    int rel;
    restart();
    go_run(r);
    en_q.push_back(r + 10); en_q.push_back(r + 20); en_q.push_back(r + 44);
    en_q.push_back(r + 54); en_q.push_back(r + 97);
    for (int k = 0; k < 101; k++) begin
      @(negedge clk);
      rel = cyc - r;
      if (rel == 16 || rel == 30 || rel == 50 || rel == 80) b_start = 1'b1;
      if (rel == 21 || rel == 36 || rel == 56 || rel == 86) b_start = 1'b0;
      if (rel == 60 || rel == 70) b_lap = 1'b1;
      if (rel == 66 || rel == 76) b_lap = 1'b0;
      while (en_q.size() != 0 && en_q[0] < cyc) begin
        n_chk++; n_fail++; $display("FAIL pause_en_missed: none at %0d", en_q.pop_front());
      end
      if (ifa.cnt_en) begin
        n_chk++;
        if (en_q.size() == 0 || en_q[0] != cyc) begin
          n_fail++; $display("FAIL pause_en_extra: pulse at rel %0d", rel);
        end else void'(en_q.pop_front());
      end
      n_chk++;
      if (ifa.cnt_clr !== (rel == 67)) begin
        n_fail++; $display("FAIL pause_clr: got %b want %b at rel %0d", ifa.cnt_clr, (rel == 67), rel);
      end
      if (rel == 23) begin
        n_chk++; if (ifa.state !== ST_PAUSE) begin n_fail++; $display("FAIL pause_enter: got %0d want 2", ifa.state); end
        n_chk++; if (ifa.state_led !== 1'b0) begin n_fail++; $display("FAIL pause_led: got %b want 0", ifa.state_led); end
      end
      if (rel == 37) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL pause_resume: got %0d want 1", ifa.state); end
      end
      if (rel == 57) begin
        n_chk++; if (ifa.state !== ST_PAUSE) begin n_fail++; $display("FAIL pause_again: got %0d want 2", ifa.state); end
      end
      if (rel == 67 || rel == 77) begin
        n_chk++; if (ifa.state !== ST_IDLE) begin n_fail++; $display("FAIL pause_idle: got %0d want 0 at rel %0d", ifa.state, rel); end
      end
      if (rel == 87) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL pause_restart: got %0d want 1", ifa.state); end
      end
    end
    n_chk++; if (en_q.size() != 0) begin n_fail++; $display("FAIL pause_en_left: %0d pending want 0", en_q.size()); end
  endtask

  task automatic test_max();
    int r;
    int rel;
    restart();
    go_run(r);
    en_q.push_back(r + 10); en_q.push_back(r + 20); en_q.push_back(r + 30);
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      rel = cyc - r;
      if (rel == 3) at_max = 1'b1;
      while (en_q.size() != 0 && en_q[0] < cyc) begin
        n_chk++; n_fail++; $display("FAIL max_wrap_en_missed: none at %0d", en_q.pop_front());
      end
      if (ifb.cnt_en) begin
        n_chk++;
        if (en_q.size() == 0 || en_q[0] != cyc) begin
          n_fail++; $display("FAIL max_wrap_en_extra: pulse at rel %0d", rel);
        end else void'(en_q.pop_front());
      end
      n_chk++;
      if (ifa.cnt_en !== 1'b0) begin
        n_fail++; $display("FAIL max_stop_en: got %b want 0 at rel %0d", ifa.cnt_en, rel);
      end
      if (rel == 5) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL max_stop_early: got %0d want 1", ifa.state); end
      end
      if (rel == 10 || rel == 32) begin
        n_chk++; if (ifa.state !== ST_PAUSE) begin n_fail++; $display("FAIL max_stop_state: got %0d want 2 at rel %0d", ifa.state, rel); end
        n_chk++; if (ifb.state !== ST_RUN) begin n_fail++; $display("FAIL max_wrap_state: got %0d want 1 at rel %0d", ifb.state, rel); end
      end
    end
    at_max = 1'b0;
    n_chk++; if (en_q.size() != 0) begin n_fail++; $display("FAIL max_en_left: %0d pending want 0", en_q.size()); end
  endtask

  task automatic test_glitch_simultaneous();
    int r;
    int rel;
    restart();
    go_run(r);
    en_q.push_back(r + 10); en_q.push_back(r + 20);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rel = cyc - r;
      if (rel == 2) b_start = 1'b1;
      if (rel == 5) b_start = 1'b0;
      if (rel == 22) begin b_start = 1'b1; b_lap = 1'b1; end
      if (rel == 28) begin b_start = 1'b0; b_lap = 1'b0; end
      while (en_q.size() != 0 && en_q[0] < cyc) begin
        n_chk++; n_fail++; $display("FAIL glitch_en_missed: none at %0d", en_q.pop_front());
      end
      if (ifa.cnt_en) begin
        n_chk++;
        if (en_q.size() == 0 || en_q[0] != cyc) begin
          n_fail++; $display("FAIL glitch_en_extra: pulse at rel %0d", rel);
        end else void'(en_q.pop_front());
      end
      if (rel == 12 || rel == 28) begin
        n_chk++; if (ifa.state !== ST_RUN) begin n_fail++; $display("FAIL glitch_ignored: got %0d want 1 at rel %0d", ifa.state, rel); end
      end
      if (rel == 29 || rel == 38) begin
        n_chk++; if (ifa.state !== ST_PAUSE) begin n_fail++; $display("FAIL both_btn: got %0d want 2 at rel %0d", ifa.state, rel); end
        n_chk++; if (ifa.disp_hold !== 1'b0) begin n_fail++; $display("FAIL both_hold: got %b want 0 at rel %0d", ifa.disp_hold, rel); end
      end
    end
    n_chk++; if (en_q.size() != 0) begin n_fail++; $display("FAIL glitch_en_left: %0d pending want 0", en_q.size()); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_clear();
    test_max();
    test_glitch_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
